pipe_sum: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor, the successor to the fixed 6-bit ripple-carry adder. Splits the operands into CHUNK-bit slices, each slice added in its own pipeline stage with the carry registered between stages. Accepts one operation per cycle under a valid/ready handshake with backpressure. Sits between the operand register file and result consumers wherever wide sums would otherwise break timing.

---
 rtl/pipe_sum_pkg.sv | 24 ++
 rtl/pipe_sum_stage.sv | 27 ++
 rtl/pipe_sum.sv | 117 +++++++++++
 tb/tb_pipe_sum.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_sum_pkg.sv
// pipe_sum_pkg: shared constants and helpers for the pipelined adder/subtractor.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits added per stage.
//   stage_count()         : derived pipeline depth for a width/chunk pair.
//   stage_t               : stage register layout for the default configuration
//                           (valid, carry, partial result, remaining operands).
//                           pipe_sum rebuilds the same layout at its own WIDTH.
package pipe_sum_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int stage_count(input int width, input int chunk);
    return width / chunk;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] res;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } stage_t;

endpackage

// File: rtl/pipe_sum_stage.sv
// sum_stage: CHUNK-bit ripple-carry adder slice built from gate-level full adders.
//   a, b : CHUNK-bit operand slices
//   ci   : carry into bit 0
//   s    : CHUNK-bit sum slice
//   co   : carry out of the slice MSB
module sum_stage #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/pipe_sum.sv
// pipe_sum: pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake
//   ain, bin, ci, sub   : operands, carry-in, subtract select
//   out_valid, out_ready: result handshake
//   sout, co            : WIDTH-bit sum/difference and carry-out (sub: 1 = no borrow)
//   ovf                 : signed overflow, present only when PIPE_SUM_OVF_EN is defined
//
// Handshake: a side transfers on a rising edge where its valid and ready are both
// high. valid never depends on ready; in_ready is combinational from out_ready and
// out_valid. While out_valid && !out_ready, every stage and all outputs hold.
module pipe_sum
  import pipe_sum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout,
  output logic             co
`ifdef PIPE_SUM_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_reg_t;

  // link[k] feeds stage k; link[STAGES] is the output register.
  stage_reg_t       link    [STAGES+1];
  logic [CHUNK-1:0] slice_s [STAGES];
  logic             slice_c [STAGES];
  logic             en;

  // Whole pipeline advances together unless a valid result is being held.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtraction folds into the add: A - B = A + ~B + 1.
  assign link[0] = '{valid: in_valid,
                     carry: ci ^ sub,
                     res:   '0,
                     a:     ain,
                     b:     sub ? ~bin : bin};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_reg_t       q;
    logic [WIDTH-1:0] res_next;

    sum_stage #(.CHUNK(CHUNK)) u_slice (
      .a  (link[k].a[k*CHUNK +: CHUNK]),
      .b  (link[k].b[k*CHUNK +: CHUNK]),
      .ci (link[k].carry),
      .s  (slice_s[k]),
      .co (slice_c[k])
    );

    // Lower slices finished earlier pass through; only slice k is filled in here.
    always_comb begin
      res_next                    = link[k].res;
      res_next[k*CHUNK +: CHUNK]  = slice_s[k];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (en) begin
        q.valid <= link[k].valid;
        q.carry <= slice_c[k];
        q.res   <= res_next;
        q.a     <= link[k].a;
        q.b     <= link[k].b;
      end
    end

    assign link[k+1] = q;
  end

  assign out_valid = link[STAGES].valid;
  assign sout      = link[STAGES].res;
  assign co        = link[STAGES].carry;

`ifdef PIPE_SUM_OVF_EN
  logic ovf_q;

  // Carry into the MSB recovered as sum ^ a ^ b at that bit; overflow when it
  // differs from the carry out of the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= slice_s[STAGES-1][CHUNK-1] ^ link[STAGES-1].a[WIDTH-1]
             ^ link[STAGES-1].b[WIDTH-1] ^ slice_c[STAGES-1];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_sum.sv
// tb_pipe_sum: directed-vector bench for pipe_sum at WIDTH=32, CHUNK=8 (4 stages).
// Define PIPE_SUM_OVF_EN for both bench and RTL to exercise the overflow output.
module tb_pipe_sum;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sout;
  logic         co;
  logic         ovf;

  int vectors    = 0;
  int miscompares = 0;

  logic [W:0] exp_q[$];

  // Directed table: {co, sout} hand-computed for each operand pair.
  logic [W-1:0] va [8] = '{32'h0000_0001, 32'h0000_00FF, 32'h0000_FFFF, 32'h00FF_FFFF,
                           32'h8000_0000, 32'h0000_0064, 32'h0000_0000, 32'h1234_5678};
  logic [W-1:0] vb [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                           32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h8765_4321};
  logic         vs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [W:0]   ve [8] = '{{1'b0, 32'h0000_0002}, {1'b0, 32'h0000_0100},
                           {1'b0, 32'h0001_0000}, {1'b0, 32'h0100_0000},
                           {1'b1, 32'h0000_0000}, {1'b1, 32'h0000_0063},
                           {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'h9999_9999}};

  pipe_sum #(.WIDTH(W), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sout      (sout),
    .co        (co)
`ifdef PIPE_SUM_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef PIPE_SUM_OVF_EN
  assign ovf = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Presents one operation, then waits (bounded) for its result with out_ready high.
  // lat counts rising edges from the capturing edge to the first out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c_in, input logic s_in,
                        output logic [W-1:0] s_out, output logic c_out,
                        output logic o_out, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ain = a; bin = b; ci = c_in; sub = s_in;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s_out = sout;
    c_out = co;
    o_out = ovf;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ain = '0; bin = '0; ci = 1'b0; sub = 1'b0;
    #3;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (sout !== 32'h0) begin miscompares++; $display("FAIL reset_sout: got %h want 00000000", sout); end
    vectors++; if (co !== 1'b0) begin miscompares++; $display("FAIL reset_co: got %b want 0", co); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef PIPE_SUM_OVF_EN
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [W-1:0] s; logic c; logic o; int lat;
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL add_wrap_latency: got %0d want 4", lat); end
    vectors++; if (s !== 32'h0) begin miscompares++; $display("FAIL add_wrap_sout: got %h want 00000000", s); end
    vectors++; if (c !== 1'b1) begin miscompares++; $display("FAIL add_wrap_co: got %b want 1", c); end
`ifdef PIPE_SUM_OVF_EN
    vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL add_wrap_ovf: got %b want 0", o); end
`endif
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, s, c, o, lat);
    vectors++; if ({c, s} !== {1'b0, 32'h2345_678A}) begin miscompares++; $display("FAIL add_ci: got %b_%h want 0_2345678a", c, s); end
    run_op(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, lat);
    vectors++; if ({c, s} !== {1'b0, 32'h0100_0000}) begin miscompares++; $display("FAIL add_chunk_carry: got %b_%h want 0_01000000", c, s); end
  endtask

  task automatic test_sub();
    logic [W-1:0] s; logic c; logic o; int lat;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, s, c, o, lat);
    vectors++; if ({c, s} !== {1'b0, 32'hFFFF_FFFE}) begin miscompares++; $display("FAIL sub_borrow: got %b_%h want 0_fffffffe", c, s); end
    run_op(32'd7, 32'd5, 1'b0, 1'b1, s, c, o, lat);
    vectors++; if ({c, s} !== {1'b1, 32'h0000_0002}) begin miscompares++; $display("FAIL sub_no_borrow: got %b_%h want 1_00000002", c, s); end
    // ci=1 with sub cancels the +1: 10 + ~3 = 6 with carry out.
    run_op(32'd10, 32'd3, 1'b1, 1'b1, s, c, o, lat);
    vectors++; if ({c, s} !== {1'b1, 32'h0000_0006}) begin miscompares++; $display("FAIL sub_ci: got %b_%h want 1_00000006", c, s); end
  endtask

`ifdef PIPE_SUM_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] s; logic c; logic o; int lat;
    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, lat);
    vectors++; if (s !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_sout: got %h want 80000000", s); end
    vectors++; if (o !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", o); end
    vectors++; if (c !== 1'b0) begin miscompares++; $display("FAIL ovf_co: got %b want 0", c); end
    run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, s, c, o, lat);
    vectors++; if ({o, c, s} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin miscompares++; $display("FAIL ovf_sub: got %b_%b_%h want 1_1_7fffffff", o, c, s); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [W:0] e;
    int first = -1;
    int last  = -1;
    int n     = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ve[i]);
    out_ready = 1'b1; ci = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; ain = va[cyc]; bin = vb[cyc]; sub = vs[cyc];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        n++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra: got %b_%h want no result", co, sout);
        end else begin
          e = exp_q.pop_front();
          if ({co, sout} !== e) begin miscompares++; $display("FAIL b2b_result: got %b_%h want %b_%h", co, sout, e[W], e[W-1:0]); end
        end
      end
    end
    vectors++; if (first !== 3) begin miscompares++; $display("FAIL b2b_first_cycle: got %0d want 3", first); end
    vectors++; if (last !== 10) begin miscompares++; $display("FAIL b2b_last_cycle: got %0d want 10", last); end
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL b2b_count: got %0d want 8", n); end
  endtask

  task automatic test_backpressure();
    logic [W:0] e;
    logic [W:0] hold;
    logic       stalled_prev = 1'b0;
    logic       took;
    int idx   = 0;
    int n     = 0;
    int extra = 0;
    hold = '0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ve[i]);
    ci = 1'b0;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = (idx < 8);
      if (idx < 8) begin ain = va[idx]; bin = vb[idx]; sub = vs[idx]; end
      #1;
      if (out_valid && !out_ready) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        if (stalled_prev) begin
          vectors++; if ({co, sout} !== hold) begin miscompares++; $display("FAIL bp_hold: got %b_%h want %b_%h", co, sout, hold[W], hold[W-1:0]); end
        end
        hold = {co, sout};
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        n++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL bp_extra: got %b_%h want no result", co, sout);
        end else begin
          e = exp_q.pop_front();
          if ({co, sout} !== e) begin miscompares++; $display("FAIL bp_result: got %b_%h want %b_%h", co, sout, e[W], e[W-1:0]); end
        end
      end
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL bp_count: got %0d want 8", n); end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL bp_duplicates: got %0d want 0", extra); end
    vectors++; if (idx !== 8) begin miscompares++; $display("FAIL bp_accepted: got %0d want 8", idx); end
  endtask

  task automatic test_reset_inflight();
    logic [W-1:0] s; logic c; logic o; int lat;
    int stale = 0;
    out_ready = 1'b1; ci = 1'b0; sub = 1'b0;
    in_valid = 1'b1; ain = 32'h1111_1111; bin = 32'h2222_2222;
    @(posedge clk); #1;
    ain = 32'h0000_0100; bin = 32'h0000_0200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if ({out_valid, sout} !== {1'b1, 32'h3333_3333}) begin miscompares++; $display("FAIL rst_pre: got %b_%h want 1_33333333", out_valid, sout); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (sout !== 32'h0) begin miscompares++; $display("FAIL rst_sout: got %h want 00000000", sout); end
    vectors++; if (co !== 1'b0) begin miscompares++; $display("FAIL rst_co: got %b want 0", co); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    vectors++; if (stale !== 0) begin miscompares++; $display("FAIL rst_stale: got %0d want 0", stale); end
    run_op(32'd3, 32'd4, 1'b0, 1'b0, s, c, o, lat);
    vectors++; if ({lat, c, s} !== {32'd4, 1'b0, 32'd7}) begin miscompares++; $display("FAIL rst_recover: got lat %0d %b_%h want lat 4 0_00000007", lat, c, s); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
`ifdef PIPE_SUM_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
